// File: rtl/cache_arb_pkg.sv
// cache_arb_pkg: shared widths, FSM states and owner tags
// for the I/D cache line arbiter.
package cache_arb_pkg;

    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_I_BUSY,
        ARB_D_BUSY,
        ARB_RELEASE
    } arb_state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_t;

endpackage

// File: rtl/cache_arbiter.sv
// cache_arbiter: shares the cacheline adaptor between the I-cache
// and the D-cache, one whole burst transaction at a time.
module cache_arbiter #(
    parameter int LINE_W      = cache_arb_pkg::LINE_W,
    parameter int ADDR_W      = cache_arb_pkg::ADDR_W,
    parameter int ROUND_ROBIN = 1
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic [ADDR_W-1:0] i_address,
    input  logic              i_read,
    output logic [LINE_W-1:0] i_line_o,
    output logic              i_resp,

    input  logic [ADDR_W-1:0] d_address,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [LINE_W-1:0] d_line_i,
    output logic [LINE_W-1:0] d_line_o,
    output logic              d_resp,

    output logic [ADDR_W-1:0] address_o,
    output logic [LINE_W-1:0] line_o,
    output logic              read_o,
    output logic              write_o,
    input  logic [LINE_W-1:0] line_i,
    input  logic              resp_i
);

    import cache_arb_pkg::*;

    arb_state_t state_q;
    owner_t     prio_q;

    logic i_req;
    logic d_req;
    logic tie_d;
    logic grant_i;
    logic grant_d;

    assign i_req = i_read;
    assign d_req = d_read | d_write;
    assign tie_d = (ROUND_ROBIN == 0) || (prio_q == OWN_D);

    // Winner selection; only ARB_IDLE may grant
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state_q == ARB_IDLE) begin
            unique case (1'b1)
                i_req && d_req: begin
                    grant_d = tie_d;
                    grant_i = !tie_d;
                end
                d_req && !i_req: grant_d = 1'b1;
                i_req && !d_req: grant_i = 1'b1;
                default: ;
            endcase
        end
    end

    // Completion is steered to the owner only; lines fan out to both
    assign i_resp   = (state_q == ARB_I_BUSY) && resp_i;
    assign d_resp   = (state_q == ARB_D_BUSY) && resp_i;
    assign i_line_o = line_i;
    assign d_line_o = line_i;

    // State, priority pointer and the request latches held for a burst
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ARB_IDLE;
            prio_q    <= OWN_D;
            address_o <= '0;
            line_o    <= '0;
            read_o    <= 1'b0;
            write_o   <= 1'b0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (grant_d) begin
                        address_o <= d_address;
                        line_o    <= d_line_i;
                        write_o   <= d_write;
                        read_o    <= !d_write;
                        prio_q    <= OWN_I;
                        state_q   <= ARB_D_BUSY;
                    end else if (grant_i) begin
                        address_o <= i_address;
                        write_o   <= 1'b0;
                        read_o    <= 1'b1;
                        prio_q    <= OWN_D;
                        state_q   <= ARB_I_BUSY;
                    end
                end
                ARB_I_BUSY, ARB_D_BUSY: begin
                    if (resp_i) begin
                        read_o  <= 1'b0;
                        write_o <= 1'b0;
                        state_q <= ARB_RELEASE;
                    end
                end
                ARB_RELEASE: state_q <= ARB_IDLE;
                default:     state_q <= ARB_IDLE;
            endcase
        end
    end

    // Protocol checks on the cache and adaptor sides
    a_d_rw_excl: assert property (
        @(posedge clk) disable iff (!reset_n)
        !(d_read && d_write));

    a_resp_busy: assert property (
        @(posedge clk) disable iff (!reset_n)
        resp_i |-> (state_q == ARB_I_BUSY || state_q == ARB_D_BUSY));

endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: scenario tasks plus a randomized transaction
// loop against a grant-rule model, on round-robin and fixed DUTs.
module tb_cache_arbiter;

    import cache_arb_pkg::*;

    localparam int LW = 256;
    localparam int AW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic [AW-1:0] i_address;
    logic [AW-1:0] d_address;
    logic          i_read;
    logic          d_read;
    logic          d_write;
    logic [LW-1:0] d_line_i;
    logic [LW-1:0] line_i;
    logic [1:0]    resp_v;

    logic [LW-1:0] i_line_rr, d_line_rr, line_rr;
    logic [LW-1:0] i_line_fp, d_line_fp, line_fp;
    logic [AW-1:0] addr_rr, addr_fp;
    logic          i_resp_rr, d_resp_rr, rd_rr, wr_rr;
    logic          i_resp_fp, d_resp_fp, rd_fp, wr_fp;

    logic [1:0]    rd_v, wr_v, iresp_v, dresp_v;
    logic [AW-1:0] addr_v [2];
    logic [LW-1:0] line_v [2];

    assign rd_v      = {rd_fp, rd_rr};
    assign wr_v      = {wr_fp, wr_rr};
    assign iresp_v   = {i_resp_fp, i_resp_rr};
    assign dresp_v   = {d_resp_fp, d_resp_rr};
    assign addr_v[0] = addr_rr;
    assign addr_v[1] = addr_fp;
    assign line_v[0] = line_rr;
    assign line_v[1] = line_fp;

    int n_checks = 0;
    int n_fail   = 0;

    cache_arbiter #(.ROUND_ROBIN(1)) u_rr (
        .clk(clk), .reset_n(reset_n),
        .i_address(i_address), .i_read(i_read),
        .i_line_o(i_line_rr), .i_resp(i_resp_rr),
        .d_address(d_address), .d_read(d_read), .d_write(d_write),
        .d_line_i(d_line_i), .d_line_o(d_line_rr), .d_resp(d_resp_rr),
        .address_o(addr_rr), .line_o(line_rr),
        .read_o(rd_rr), .write_o(wr_rr),
        .line_i(line_i), .resp_i(resp_v[0])
    );

    cache_arbiter #(.ROUND_ROBIN(0)) u_fp (
        .clk(clk), .reset_n(reset_n),
        .i_address(i_address), .i_read(i_read),
        .i_line_o(i_line_fp), .i_resp(i_resp_fp),
        .d_address(d_address), .d_read(d_read), .d_write(d_write),
        .d_line_i(d_line_i), .d_line_o(d_line_fp), .d_resp(d_resp_fp),
        .address_o(addr_fp), .line_o(line_fp),
        .read_o(rd_fp), .write_o(wr_fp),
        .line_i(line_i), .resp_i(resp_v[1])
    );

    // Reference grant rule: lone requester wins; ties go to D when
    // fixed, else to whichever side did not win last time.
    function automatic bit pick_d(bit ireq, bit dreq, bit rr, bit last_d);
        if (!ireq) return 1'b1;
        if (!dreq) return 1'b0;
        return rr ? !last_d : 1'b1;
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] l;
        for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        i_read    = 1'b0;
        d_read    = 1'b0;
        d_write   = 1'b0;
        resp_v    = '0;
        i_address = '0;
        d_address = '0;
        d_line_i  = '0;
        line_i    = '0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        reset_n   = 1'b0;
        i_read    = 1'b1;
        d_write   = 1'b1;
        i_address = 32'h1234_0000;
        d_address = 32'h5678_0000;
        d_line_i  = rand_line();
        tick();
        tick();
        for (int v = 0; v < 2; v++) begin
            n_checks++; if (rd_v[v] !== 1'b0) begin n_fail++; $display("FAIL reset.read_o[%0d] got %b want 0", v, rd_v[v]); end
            n_checks++; if (wr_v[v] !== 1'b0) begin n_fail++; $display("FAIL reset.write_o[%0d] got %b want 0", v, wr_v[v]); end
            n_checks++; if (addr_v[v] !== '0) begin n_fail++; $display("FAIL reset.address_o[%0d] got %h want 0", v, addr_v[v]); end
            n_checks++; if (line_v[v] !== '0) begin n_fail++; $display("FAIL reset.line_o[%0d] got %h want 0", v, line_v[v]); end
            n_checks++; if (iresp_v[v] !== 1'b0 || dresp_v[v] !== 1'b0) begin n_fail++; $display("FAIL reset.resp[%0d] got i=%b d=%b want 0", v, iresp_v[v], dresp_v[v]); end
        end
        n_checks++; if (u_rr.state_q !== ARB_IDLE) begin n_fail++; $display("FAIL reset.state got %s want ARB_IDLE", u_rr.state_q.name()); end
        i_read  = 1'b0;
        d_write = 1'b0;
        reset_n = 1'b1;
        tick();
        n_checks++; if (rd_rr !== 1'b0 || wr_rr !== 1'b0) begin n_fail++; $display("FAIL reset.idle rd=%b wr=%b want 0", rd_rr, wr_rr); end
    endtask

    task automatic test_i_read();
        logic [LW-1:0] a5;
        do_reset();
        a5        = {32{8'hA5}};
        i_address = 32'h0000_1000;
        i_read    = 1'b1;
        tick();
        n_checks++; if (rd_rr !== 1'b1 || wr_rr !== 1'b0) begin n_fail++; $display("FAIL iread.grant rd=%b wr=%b want 1/0", rd_rr, wr_rr); end
        n_checks++; if (addr_rr !== 32'h0000_1000) begin n_fail++; $display("FAIL iread.addr got %h want 00001000", addr_rr); end
        n_checks++; if (line_rr !== '0) begin n_fail++; $display("FAIL iread.line_o got %h want 0", line_rr); end
        tick();
        line_i    = a5;
        resp_v[0] = 1'b1;
        #1;
        n_checks++; if (i_resp_rr !== 1'b1) begin n_fail++; $display("FAIL iread.i_resp got %b want 1", i_resp_rr); end
        n_checks++; if (i_line_rr !== a5) begin n_fail++; $display("FAIL iread.i_line got %h want %h", i_line_rr, a5); end
        n_checks++; if (d_resp_rr !== 1'b0) begin n_fail++; $display("FAIL iread.d_resp got %b want 0", d_resp_rr); end
        tick();
        resp_v[0] = 1'b0;
        i_read    = 1'b0;
        n_checks++; if (rd_rr !== 1'b0) begin n_fail++; $display("FAIL iread.release rd got %b want 0", rd_rr); end
        n_checks++; if (i_resp_rr !== 1'b0) begin n_fail++; $display("FAIL iread.pulse i_resp got %b want 0", i_resp_rr); end
        tick();
        n_checks++; if (rd_rr !== 1'b0) begin n_fail++; $display("FAIL iread.idle rd got %b want 0", rd_rr); end
    endtask

    task automatic test_d_write();
        logic [LW-1:0] wl;
        do_reset();
        wl        = {4{64'h0123_4567_89AB_CDEF}};
        d_address = 32'h8000_0040;
        d_line_i  = wl;
        d_write   = 1'b1;
        tick();
        for (int c = 0; c < 4; c++) begin
            n_checks++; if (wr_rr !== 1'b1 || rd_rr !== 1'b0) begin n_fail++; $display("FAIL dwrite.busy%0d wr=%b rd=%b want 1/0", c, wr_rr, rd_rr); end
            n_checks++; if (addr_rr !== 32'h8000_0040) begin n_fail++; $display("FAIL dwrite.addr%0d got %h want 80000040", c, addr_rr); end
            n_checks++; if (line_rr !== wl) begin n_fail++; $display("FAIL dwrite.line%0d got %h want %h", c, line_rr, wl); end
            d_line_i  = rand_line();
            d_address = $urandom;
            tick();
        end
        line_i    = rand_line();
        resp_v[0] = 1'b1;
        #1;
        n_checks++; if (d_resp_rr !== 1'b1 || i_resp_rr !== 1'b0) begin n_fail++; $display("FAIL dwrite.resp d=%b i=%b want 1/0", d_resp_rr, i_resp_rr); end
        tick();
        resp_v[0] = 1'b0;
        d_write   = 1'b0;
        n_checks++; if (wr_rr !== 1'b0 || rd_rr !== 1'b0) begin n_fail++; $display("FAIL dwrite.release wr=%b rd=%b want 0", wr_rr, rd_rr); end
        n_checks++; if (d_resp_rr !== 1'b0) begin n_fail++; $display("FAIL dwrite.pulse d_resp got %b want 0", d_resp_rr); end
    endtask

    task automatic test_simultaneous();
        bit seq [2][$];
        int cnt [2];
        int gap [2];
        bit prv [2];
        bit last_d;
        bit e;
        do_reset();
        i_address = 32'h0000_0100;
        d_address = 32'h0000_0200;
        i_read    = 1'b1;
        d_read    = 1'b1;
        for (int v = 0; v < 2; v++) begin
            cnt[v] = 0;
            gap[v] = 0;
            prv[v] = 1'b0;
        end
        for (int c = 0; c < 48; c++) begin
            tick();
            resp_v = '0;
            for (int v = 0; v < 2; v++) begin
                if (rd_v[v] && !prv[v]) begin
                    if (seq[v].size() > 0) begin
                        n_checks++; if (gap[v] != 2) begin n_fail++; $display("FAIL simul.gap[%0d] got %0d idle cycles want 2", v, gap[v]); end
                    end
                    seq[v].push_back(addr_v[v] == 32'h0000_0200);
                    cnt[v] = 0;
                end
                if (rd_v[v]) begin
                    cnt[v]++;
                    gap[v] = 0;
                    if (cnt[v] == 2) resp_v[v] = 1'b1;
                end else begin
                    gap[v]++;
                end
                prv[v] = rd_v[v];
            end
        end
        resp_v = '0;
        i_read = 1'b0;
        d_read = 1'b0;
        for (int v = 0; v < 2; v++) begin
            n_checks++; if (seq[v].size() < 6) begin n_fail++; $display("FAIL simul.count[%0d] got %0d grants want >=6", v, seq[v].size()); end
            last_d = 1'b0;
            for (int j = 0; j < 6 && j < seq[v].size(); j++) begin
                e      = pick_d(1'b1, 1'b1, v == 0, last_d);
                last_d = e;
                n_checks++; if (seq[v][j] !== e) begin n_fail++; $display("FAIL simul.owner[%0d][%0d] got D=%b want D=%b", v, j, seq[v][j], e); end
            end
        end
    endtask

    task automatic test_mid_change();
        do_reset();
        d_address = 32'h0000_3000;
        d_read    = 1'b1;
        tick();
        n_checks++; if (rd_rr !== 1'b1 || addr_rr !== 32'h0000_3000) begin n_fail++; $display("FAIL mid.grant rd=%b addr=%h want 1/00003000", rd_rr, addr_rr); end
        d_address = 32'hDEAD_0000;
        i_address = 32'h0000_4000;
        i_read    = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++; if (addr_rr !== 32'h0000_3000 || rd_rr !== 1'b1) begin n_fail++; $display("FAIL mid.hold%0d addr=%h rd=%b want 00003000/1", c, addr_rr, rd_rr); end
        end
        resp_v[0] = 1'b1;
        #1;
        n_checks++; if (d_resp_rr !== 1'b1 || i_resp_rr !== 1'b0) begin n_fail++; $display("FAIL mid.resp d=%b i=%b want 1/0", d_resp_rr, i_resp_rr); end
        tick();
        resp_v[0] = 1'b0;
        d_read    = 1'b0;
        n_checks++; if (rd_rr !== 1'b0) begin n_fail++; $display("FAIL mid.release rd got %b want 0", rd_rr); end
        tick();
        n_checks++; if (rd_rr !== 1'b0) begin n_fail++; $display("FAIL mid.idle rd got %b want 0", rd_rr); end
        tick();
        n_checks++; if (rd_rr !== 1'b1 || addr_rr !== 32'h0000_4000) begin n_fail++; $display("FAIL mid.igrant rd=%b addr=%h want 1/00004000", rd_rr, addr_rr); end
        resp_v[0] = 1'b1;
        #1;
        n_checks++; if (i_resp_rr !== 1'b1) begin n_fail++; $display("FAIL mid.iresp got %b want 1", i_resp_rr); end
        tick();
        resp_v[0] = 1'b0;
        i_read    = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [LW-1:0] l;
        do_reset();
        i_address = 32'h0000_5000;
        i_read    = 1'b1;
        tick();
        n_checks++; if (rd_rr !== 1'b1) begin n_fail++; $display("FAIL rstmid.grant rd got %b want 1", rd_rr); end
        tick();
        reset_n = 1'b0;
        i_read  = 1'b0;
        tick();
        n_checks++; if (rd_rr !== 1'b0 || wr_rr !== 1'b0) begin n_fail++; $display("FAIL rstmid.req rd=%b wr=%b want 0", rd_rr, wr_rr); end
        n_checks++; if (addr_rr !== '0 || line_rr !== '0) begin n_fail++; $display("FAIL rstmid.latch addr=%h line=%h want 0", addr_rr, line_rr); end
        n_checks++; if (i_resp_rr !== 1'b0) begin n_fail++; $display("FAIL rstmid.i_resp got %b want 0", i_resp_rr); end
        n_checks++; if (u_rr.state_q !== ARB_IDLE) begin n_fail++; $display("FAIL rstmid.state got %s want ARB_IDLE", u_rr.state_q.name()); end
        reset_n = 1'b1;
        tick();
        i_address = 32'h0000_6000;
        i_read    = 1'b1;
        tick();
        n_checks++; if (rd_rr !== 1'b1 || addr_rr !== 32'h0000_6000) begin n_fail++; $display("FAIL rstmid.fresh rd=%b addr=%h want 1/00006000", rd_rr, addr_rr); end
        l         = rand_line();
        line_i    = l;
        resp_v[0] = 1'b1;
        #1;
        n_checks++; if (i_resp_rr !== 1'b1 || i_line_rr !== l) begin n_fail++; $display("FAIL rstmid.done resp=%b line=%h want 1/%h", i_resp_rr, i_line_rr, l); end
        tick();
        resp_v[0] = 1'b0;
        i_read    = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        d_address = 32'h0000_7000;
        d_read    = 1'b1;
        tick();
        n_checks++; if (rd_rr !== 1'b1) begin n_fail++; $display("FAIL b2b.first rd got %b want 1", rd_rr); end
        resp_v[0] = 1'b1;
        #1;
        n_checks++; if (d_resp_rr !== 1'b1) begin n_fail++; $display("FAIL b2b.resp1 got %b want 1", d_resp_rr); end
        tick();
        resp_v[0] = 1'b0;
        n_checks++; if (rd_rr !== 1'b0) begin n_fail++; $display("FAIL b2b.release rd got %b want 0", rd_rr); end
        tick();
        n_checks++; if (rd_rr !== 1'b0) begin n_fail++; $display("FAIL b2b.idle rd got %b want 0", rd_rr); end
        tick();
        n_checks++; if (rd_rr !== 1'b1) begin n_fail++; $display("FAIL b2b.second rd got %b want 1", rd_rr); end
        resp_v[0] = 1'b1;
        #1;
        tick();
        resp_v[0] = 1'b0;
        d_read    = 1'b0;
        for (int c = 0; c < 3; c++) begin
            n_checks++; if (rd_rr !== 1'b0) begin n_fail++; $display("FAIL b2b.drop%0d rd got %b want 0", c, rd_rr); end
            tick();
        end
    endtask

    task automatic test_random();
        bit            i_pend, d_pend, win_d, last_d, exp_wr, w;
        logic [AW-1:0] exp_addr;
        logic [LW-1:0] exp_line, rl;
        int            lat;
        do_reset();
        i_pend   = 1'b0;
        d_pend   = 1'b0;
        last_d   = 1'b0;
        exp_line = '0;
        for (int it = 0; it < 60; it++) begin
            if (!i_pend && $urandom_range(1) == 1) begin
                i_pend    = 1'b1;
                i_read    = 1'b1;
                i_address = $urandom;
            end
            if (!d_pend && $urandom_range(1) == 1) begin
                d_pend    = 1'b1;
                w         = 1'($urandom_range(1));
                d_write   = w;
                d_read    = !w;
                d_address = $urandom;
                d_line_i  = rand_line();
            end
            if (!i_pend && !d_pend) begin
                i_pend    = 1'b1;
                i_read    = 1'b1;
                i_address = $urandom;
            end
            win_d    = pick_d(i_pend, d_pend, 1'b1, last_d);
            last_d   = win_d;
            exp_addr = win_d ? d_address : i_address;
            exp_wr   = win_d && d_write;
            if (win_d) exp_line = d_line_i;
            lat = $urandom_range(3);
            for (int c = 0; c <= lat; c++) begin
                tick();
                n_checks++; if (rd_rr !== !exp_wr || wr_rr !== exp_wr) begin n_fail++; $display("FAIL rand%0d.req rd=%b wr=%b want %b/%b", it, rd_rr, wr_rr, !exp_wr, exp_wr); end
                n_checks++; if (addr_rr !== exp_addr) begin n_fail++; $display("FAIL rand%0d.addr got %h want %h", it, addr_rr, exp_addr); end
                n_checks++; if (line_rr !== exp_line) begin n_fail++; $display("FAIL rand%0d.line got %h want %h", it, line_rr, exp_line); end
                n_checks++; if (i_resp_rr !== 1'b0 || d_resp_rr !== 1'b0) begin n_fail++; $display("FAIL rand%0d.early resp i=%b d=%b want 0", it, i_resp_rr, d_resp_rr); end
                if (win_d) begin
                    d_address = $urandom;
                    d_line_i  = rand_line();
                end else begin
                    i_address = $urandom;
                end
            end
            rl        = rand_line();
            line_i    = rl;
            resp_v[0] = 1'b1;
            #1;
            n_checks++; if (d_resp_rr !== win_d || i_resp_rr !== !win_d) begin n_fail++; $display("FAIL rand%0d.resp i=%b d=%b want %b/%b", it, i_resp_rr, d_resp_rr, !win_d, win_d); end
            n_checks++; if ((win_d ? d_line_rr : i_line_rr) !== rl) begin n_fail++; $display("FAIL rand%0d.rline got %h want %h", it, win_d ? d_line_rr : i_line_rr, rl); end
            tick();
            resp_v[0] = 1'b0;
            n_checks++; if (rd_rr !== 1'b0 || wr_rr !== 1'b0) begin n_fail++; $display("FAIL rand%0d.release rd=%b wr=%b want 0", it, rd_rr, wr_rr); end
            if ($urandom_range(1) == 0) begin
                if (win_d) begin
                    d_pend  = 1'b0;
                    d_read  = 1'b0;
                    d_write = 1'b0;
                end else begin
                    i_pend = 1'b0;
                    i_read = 1'b0;
                end
            end
            tick();
            n_checks++; if (rd_rr !== 1'b0 || wr_rr !== 1'b0) begin n_fail++; $display("FAIL rand%0d.idle rd=%b wr=%b want 0", it, rd_rr, wr_rr); end
        end
        i_read  = 1'b0;
        d_read  = 1'b0;
        d_write = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, %0d checks done", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_i_read();
        test_d_write();
        test_simultaneous();
        test_mid_change();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
Arbitrates between the instruction cache (read-only) and the data cache (read/write) for the single line-granular port of the cacheline adaptor.
- Sits directly upstream of the adaptor.
- Latches the winning request's address and write line, and holds them stable for the whole burst transaction.
- Routes the adaptor's response and read line back to the owning cache only.
- Guarantees one idle cycle between transactions, so the adaptor never re-triggers on a stale request.

Parameters:
LINE_W, 256, cache line width in bits (4 x 64-bit bursts downstream)
ADDR_W, 32, physical address width
ROUND_ROBIN, 1, 1 = alternate priority after each grant; 0 = fixed data-cache priority

Ports:
clk  in  1  clock
reset_n  in  1  reset; synchronous, active-low
i_address  in  ADDR_W  I-cache line address
i_read  in  1  I-cache line read request; level, held until i_resp
i_line_o  out  LINE_W  line returned to I-cache
i_resp  out  1  I-cache transaction complete, one-cycle pulse
d_address  in  ADDR_W  D-cache line address
d_read  in  1  D-cache line read request; level
d_write  in  1  D-cache line write-back request; level
d_line_i  in  LINE_W  D-cache write-back line
d_line_o  out  LINE_W  line returned to D-cache
d_resp  out  1  D-cache transaction complete, one-cycle pulse
address_o  out  ADDR_W  to adaptor address_i
line_o  out  LINE_W  to adaptor line_i
read_o  out  1  to adaptor read_i
write_o  out  1  to adaptor write_i
line_i  in  LINE_W  from adaptor line_o
resp_i  in  1  from adaptor resp_o

Behaviour:
- States (shared enum): ARB_IDLE, ARB_I_BUSY, ARB_D_BUSY, ARB_RELEASE.
- Reset (reset_n=0 at a clk edge):
  - state=ARB_IDLE; read_o=write_o=0; address_o=0; line_o=0.
  - i_resp=d_resp=0; priority pointer = data cache.
  - Applies mid-transaction too: the in-flight transaction is abandoned and no resp is issued.
  - The adaptor shares reset_n.
- Registered outputs: address_o, line_o, read_o, write_o. Combinational outputs: i_resp, d_resp, i_line_o, d_line_o.
- ARB_IDLE grant decision:
  - Requestors: I = i_read; D = d_read|d_write.
  - Only one requesting -> grant it.
  - Both requesting -> grant the priority side. Priority is D if ROUND_ROBIN=0; otherwise the side not granted last.
  - On grant, at the next edge: latch address_o; set line_o=d_line_i (D grant) or hold the previous line_o (I grant); set read_o/write_o; go to the owner's BUSY state; update the pointer to the other side.
  - Latency: request seen in cycle N -> read_o/write_o high in cycle N+1.
- D requests:
  - d_write=1 -> write_o=1, read_o=0. d_write has precedence over d_read.
  - d_read & d_write both 1 is a protocol violation; simulation-only assertion.
- ARB_x_BUSY:
  - address_o, line_o, read_o, write_o hold constant. The adaptor re-samples address and line each cycle, so this is mandatory.
  - Request changes from either cache are ignored.
  - When resp_i=1: the owner's resp = 1 in the same cycle; the owner's line_o output = line_i. Next state is ARB_RELEASE, with read_o=write_o=0 at that edge.
- ARB_RELEASE:
  - Exactly one cycle; all request outputs are 0 and no grant is evaluated; next state ARB_IDLE.
  - This covers the cache dropping its request one cycle after resp, and the adaptor's idle cycle.
- Non-owner resp is always 0. i_line_o and d_line_o are don't-care when the matching resp=0; drive line_i to both.
- resp_i=1 in ARB_IDLE or ARB_RELEASE is ignored; simulation-only assertion.
- No timeout; a hung adaptor holds BUSY indefinitely.
- Target size: ~150-250 lines RTL.

Decomposition:
- cache_arb_pkg holds:
  - the arb_state_t enum;
  - localparams LINE_W=256 and ADDR_W=32;
  - owner_t (OWN_I, OWN_D).
- No sub-module. Grant logic is a single always_comb; the state register and latches are a single always_ff.

Test Plan:
- I-only read: i_read=1, addr 0x0000_1000; adaptor returns line 0xA5..A5 -> read_o high N+1 with address_o=0x1000; i_resp one cycle with i_line_o=0xA5..A5; d_resp stays 0; read_o low the cycle after resp.
- D write-back: d_write=1, addr 0x8000_0040, d_line_i=0x0123..CDEF -> write_o=1, line_o and address_o stable every BUSY cycle; d_resp pulse; then one RELEASE cycle with write_o=0.
- Simultaneous: i_read and d_read both held continuously (each cache re-asserts after its resp), ROUND_ROBIN=1 -> grants D, I, D alternate; each transaction separated by exactly one RELEASE cycle. With ROUND_ROBIN=0, D wins every tie.
- Request change mid-burst: after a D grant, change d_address to 0xDEAD_0000 and assert i_read -> address_o unchanged; I granted only after RELEASE.
- Reset mid-operation: reset_n=0 during ARB_I_BUSY -> next cycle all outputs 0, state ARB_IDLE, no i_resp; a fresh i_read after reset completes normally.
- Back-to-back same cache: D holds d_read through the resp cycle -> no second read_o in the RELEASE cycle; a new read starts only if d_read is still 1 in ARB_IDLE.
